// File: rtl/regfile_pkg.sv
// Shared types, defaults and index helper for the multi-entry register file.
package regfile_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // True when index addresses an existing register (matters when nregs is not a power of two).
  function automatic logic idx_valid(input int index, input int nregs);
    return (index < nregs);
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear-sweep sequencer: zeroes one register per cycle behind a busy flag.
//
//  state | meaning
//  IDLE  | no sweep; clr pulse starts a sweep at index 0
//  SWEEP | clear strobe active for index cnt; returns to IDLE after index NREGS-1
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          sysclk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_idx
);

  // The counter carries an extra bit so NREGS == 2**AW never wraps before the compare.
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  state_t      state;
  logic [AW:0] cnt;

  // Sweep FSM with registered busy flag.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en  = busy;
  assign clr_idx = cnt[AW-1:0];

endmodule

// File: rtl/regfile_multi.sv
// NREGS x WIDTH register file: one write port, two registered read ports,
// optional write-through bypass and a hardware clear sweep.
module regfile_multi
  import regfile_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] w,
  input  logic             we,
  input  logic [AW-1:0]    wsel,
  input  logic [AW-1:0]    rsel0,
  input  logic [AW-1:0]    rsel1,
  input  logic             clr,
  output logic [WIDTH-1:0] read0,
  output logic [WIDTH-1:0] read1,
  output logic             busy,
  output logic             drop_err
);

  logic [WIDTH-1:0] mem [NREGS];
  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             w_valid, r0_valid, r1_valid;
  logic             wr_acc, drop_set;
  logic [WIDTH-1:0] rd0_nxt, rd1_nxt;

  regfile_clr_seq #(.NREGS(NREGS)) u_clr_seq (
    .sysclk  (sysclk),
    .rst_n   (rst_n),
    .clr     (clr),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  assign w_valid  = idx_valid(int'({{(32-AW){1'b0}}, wsel}), NREGS);
  assign r0_valid = idx_valid(int'({{(32-AW){1'b0}}, rsel0}), NREGS);
  assign r1_valid = idx_valid(int'({{(32-AW){1'b0}}, rsel1}), NREGS);

  // A clr pulse or a running sweep takes priority over the write port.
  assign wr_acc   = we && w_valid && !busy && !clr;
  assign drop_set = we && w_valid && (busy || clr);

  // Next read data: out-of-range reads return zero; bypass only from the write port.
  always_comb begin
    rd0_nxt = '0;
    rd1_nxt = '0;
    if (r0_valid) begin
      if ((BYPASS != 0) && wr_acc && (wsel == rsel0)) rd0_nxt = w;
      else                                            rd0_nxt = mem[rsel0];
    end
    if (r1_valid) begin
      if ((BYPASS != 0) && wr_acc && (wsel == rsel1)) rd1_nxt = w;
      else                                            rd1_nxt = mem[rsel1];
    end
  end

  // Storage: sweep clear or accepted write.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc) begin
      mem[wsel] <= w;
    end
  end

  // Registered read ports.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      read0 <= '0;
      read1 <= '0;
    end else begin
      read0 <= rd0_nxt;
      read1 <= rd1_nxt;
    end
  end

  // Sticky discarded-write flag, cleared only by reset.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)        drop_err <= 1'b0;
    else if (drop_set) drop_err <= 1'b1;
  end

endmodule

// File: tb/tb_regfile_multi.sv
// Directed bench for regfile_multi: BYPASS=1, BYPASS=0 and NREGS=3 instances share stimulus.
module tb_regfile_multi;

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [7:0] w      = '0;
  logic       we     = 1'b0;
  logic [1:0] wsel   = '0;
  logic [1:0] rsel0  = '0;
  logic [1:0] rsel1  = '0;
  logic       clr    = 1'b0;

  logic [7:0] a_r0, a_r1, b_r0, b_r1, c_r0, c_r1;
  logic       a_busy, b_busy, c_busy, a_drop, b_drop, c_drop;

  int total = 0;
  int passed = 0;

  always #5 sysclk = ~sysclk;

  regfile_multi #(.WIDTH(8), .NREGS(4), .BYPASS(1)) dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .w(w), .we(we), .wsel(wsel),
    .rsel0(rsel0), .rsel1(rsel1), .clr(clr),
    .read0(a_r0), .read1(a_r1), .busy(a_busy), .drop_err(a_drop));

  regfile_multi #(.WIDTH(8), .NREGS(4), .BYPASS(0)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .w(w), .we(we), .wsel(wsel),
    .rsel0(rsel0), .rsel1(rsel1), .clr(clr),
    .read0(b_r0), .read1(b_r1), .busy(b_busy), .drop_err(b_drop));

  regfile_multi #(.WIDTH(8), .NREGS(3), .BYPASS(1)) dut_c (
    .sysclk(sysclk), .rst_n(rst_n), .w(w), .we(we), .wsel(wsel),
    .rsel0(rsel0), .rsel1(rsel1), .clr(clr),
    .read0(c_r0), .read1(c_r1), .busy(c_busy), .drop_err(c_drop));

  typedef struct {
    logic       we;
    logic [1:0] wsel;
    logic [7:0] w;
    logic [1:0] rsel0;
    logic [1:0] rsel1;
    logic [7:0] ea0, ea1;
    logic [7:0] eb0, eb1;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (a_busy && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'd0, a_busy}, 32'd0);
  endtask

  initial begin
    int nbusy;

    //          we wsel w      r0 r1  ea0    ea1    eb0    eb1
    vecs[0]  = '{1, 2, 8'hA5, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 2, 0, 8'hA5, 8'h00, 8'hA5, 8'h00};
    vecs[2]  = '{0, 1, 8'hFF, 1, 2, 8'h00, 8'hA5, 8'h00, 8'hA5};
    vecs[3]  = '{0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[4]  = '{1, 3, 8'h3C, 3, 3, 8'h3C, 8'h3C, 8'h00, 8'h00};
    vecs[5]  = '{0, 0, 8'h00, 3, 2, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
    vecs[6]  = '{1, 0, 8'h11, 0, 3, 8'h11, 8'h3C, 8'h00, 8'h3C};
    vecs[7]  = '{1, 1, 8'h22, 1, 0, 8'h22, 8'h11, 8'h00, 8'h11};
    vecs[8]  = '{1, 2, 8'h33, 2, 1, 8'h33, 8'h22, 8'hA5, 8'h22};
    vecs[9]  = '{1, 3, 8'h44, 3, 2, 8'h44, 8'h33, 8'h3C, 8'h33};
    vecs[10] = '{0, 0, 8'h00, 3, 0, 8'h44, 8'h11, 8'h44, 8'h11};

    // Reset state
    #3;
    check("reset_read0", {24'd0, a_r0}, 32'd0);
    check("reset_read1", {24'd0, a_r1}, 32'd0);
    check("reset_busy", {31'd0, a_busy}, 32'd0);
    check("reset_drop", {31'd0, a_drop}, 32'd0);
    #5;
    rst_n = 1'b1;
    tick();

    // Table-driven writes, reads, gating and bypass
    for (int i = 0; i < 11; i++) begin
      we = vecs[i].we; wsel = vecs[i].wsel; w = vecs[i].w;
      rsel0 = vecs[i].rsel0; rsel1 = vecs[i].rsel1;
      tick();
      check($sformatf("vec%0d_a_read0", i), {24'd0, a_r0}, {24'd0, vecs[i].ea0});
      check($sformatf("vec%0d_a_read1", i), {24'd0, a_r1}, {24'd0, vecs[i].ea1});
      check($sformatf("vec%0d_b_read0", i), {24'd0, b_r0}, {24'd0, vecs[i].eb0});
      check($sformatf("vec%0d_b_read1", i), {24'd0, b_r1}, {24'd0, vecs[i].eb1});
    end
    we = 1'b0;
    check("no_drop_after_writes", {31'd0, a_drop}, 32'd0);

    // Clear sweep with rsel0=3 held
    rsel0 = 2'd3; rsel1 = 2'd0;
    check("busy_before_clr", {31'd0, a_busy}, 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      if (a_busy) nbusy++;
      check($sformatf("sweep_read0_c%0d", i), {24'd0, a_r0}, (i <= 4) ? 32'h44 : 32'h0);
    end
    check("sweep_busy_cycles", nbusy, 4);
    rsel0 = 2'd0; rsel1 = 2'd1;
    tick();
    check("swept_reg0", {24'd0, a_r0}, 32'd0);
    check("swept_reg1", {24'd0, a_r1}, 32'd0);
    rsel0 = 2'd2; rsel1 = 2'd3;
    tick();
    check("swept_reg2", {24'd0, a_r0}, 32'd0);
    check("swept_reg3", {24'd0, a_r1}, 32'd0);

    // clr + we together: clr wins, write dropped
    clr = 1'b1; we = 1'b1; wsel = 2'd0; w = 8'h55;
    tick();
    clr = 1'b0; we = 1'b0;
    check("clr_we_busy", {31'd0, a_busy}, 32'd1);
    wait_idle("clr_we_sweep_done");
    rsel0 = 2'd0;
    tick();
    check("clr_we_reg0", {24'd0, a_r0}, 32'd0);
    check("clr_we_drop", {31'd0, a_drop}, 32'd1);

    // Write during last sweep cycle to an already-cleared register is discarded
    do_reset();
    check("drop_cleared_by_reset", {31'd0, a_drop}, 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick(); tick();
    clr = 1'b1;          // ignored while busy
    tick();
    clr = 1'b0;
    we = 1'b1; wsel = 2'd0; w = 8'h77;
    tick();
    we = 1'b0;
    check("busy_write_sweep_done", {31'd0, a_busy}, 32'd0);
    rsel0 = 2'd0;
    tick();
    check("busy_write_reg0", {24'd0, a_r0}, 32'd0);
    check("busy_write_drop", {31'd0, a_drop}, 32'd1);
    check("clr_while_busy_ignored", {31'd0, a_busy}, 32'd0);
    tick();
    check("drop_sticky", {31'd0, a_drop}, 32'd1);
    do_reset();
    check("drop_after_rst", {31'd0, a_drop}, 32'd0);

    // Mid-sweep reset
    we = 1'b1; wsel = 2'd2; w = 8'h99; rsel0 = 2'd2;
    tick();
    we = 1'b0;
    tick();
    check("pre_sweep_reg2", {24'd0, a_r0}, 32'h99);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("mid_sweep_busy", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    check("mid_rst_read0", {24'd0, a_r0}, 32'd0);
    #5;
    rst_n = 1'b1;
    tick();
    check("post_rst_read0", {24'd0, a_r0}, 32'd0);
    check("post_rst_busy", {31'd0, a_busy}, 32'd0);

    // Odd depth NREGS=3
    we = 1'b1; wsel = 2'd3; w = 8'hEE; rsel0 = 2'd3; rsel1 = 2'd2;
    tick();
    we = 1'b0;
    check("odd_read0_oor", {24'd0, c_r0}, 32'd0);
    check("odd_read1", {24'd0, c_r1}, 32'd0);
    check("odd_drop", {31'd0, c_drop}, 32'd0);
    tick();
    check("odd_read0_oor_again", {24'd0, c_r0}, 32'd0);
    we = 1'b1; wsel = 2'd2; w = 8'h5A; rsel0 = 2'd2;
    tick();
    we = 1'b0;
    check("odd_bypass_reg2", {24'd0, c_r0}, 32'h5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised successor to the team's 2-entry, 8-bit register file.
- Provides NREGS registers of WIDTH bits, one write port with explicit enable, two registered read ports and optional write-through bypass.
- Adds a hardware clear-sweep engine that zeroes every register, one per cycle, behind a busy flag.
- Sits between the datapath control unit and the ALU operand inputs.

Parameters:
- WIDTH, 8: data width of each register and of the read/write ports.
- NREGS, 4: number of registers; legal range 2..256.
- BYPASS, 1: 1 = a read in the same cycle as a write to the same index returns the new data; 0 = it returns the old data.
- AW, $clog2(NREGS): index width. Derived; never overridden.

Ports:
- sysclk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- w, input, WIDTH: write data.
- we, input, 1: write enable. When low, no register changes (the predecessor wrote every cycle).
- wsel, input, AW: write register index.
- rsel0, input, AW: read port 0 register index.
- rsel1, input, AW: read port 1 register index.
- clr, input, 1: single-cycle pulse that starts a clear sweep.
- read0, output, WIDTH: registered read data, port 0.
- read1, output, WIDTH: registered read data, port 1.
- busy, output, 1: high while a clear sweep is in progress.
- drop_err, output, 1: sticky flag; set when a write is discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, read0 = read1 = 0, busy = 0, drop_err = 0.
  - FSM = IDLE, sweep index = 0.
  - Release is synchronous to sysclk.
- Reads:
  - Each rising edge: readN <= reg[rselN].
  - One-cycle latency, always enabled, no read enable.
  - Both ports may select the same index.
- Out-of-range indices (NREGS not a power of two):
  - rselN >= NREGS -> readN <= 0.
  - wsel >= NREGS with we=1 -> write ignored; drop_err not set.
- Writes:
  - we=1 in IDLE with no clr: reg[wsel] <= w at the edge.
- Bypass, when we=1 and wsel==rselN in the same cycle (write accepted):
  - BYPASS=1: readN <= w.
  - BYPASS=0: readN <= old reg value.
- FSM states:
  - IDLE: busy=0.
    - clr=1 -> go to SWEEP, index <= 0.
  - SWEEP: busy=1.
    - Each cycle: reg[index] <= 0 and index <= index+1.
    - When index == NREGS-1, that register is cleared and the FSM returns to IDLE.
    - A sweep takes exactly NREGS cycles; busy is high for NREGS cycles starting the cycle after the clr pulse.
- Write/clear conflicts:
  - clr and we together in IDLE -> clr wins; write discarded; drop_err <= 1.
  - we=1 while busy -> write discarded; drop_err <= 1.
  - drop_err clears only on reset.
- clr while busy: ignored; the sweep is not restarted.
- Reads during SWEEP return current stored contents. A register being zeroed this cycle reads its old value; the zero is visible on the next read. No bypass from the sweep path.
- Reset mid-sweep: immediate return to IDLE, all registers zero, busy=0.
- Width rules:
  - No arithmetic on data.
  - Sweep index counter is AW+1 bits wide, to avoid wrap when NREGS = 2^AW.

Decomposition:
- Shared package regfile_pkg:
  - FSM state enum (IDLE, SWEEP).
  - Default WIDTH/NREGS constants.
  - Function idx_valid(index, NREGS).
- One natural sub-module, regfile_clr_seq: holds the FSM, sweep counter, busy and per-cycle clear strobe/index.
- Storage array, read muxes and bypass stay in regfile_multi.

Test Plan (WIDTH=8, NREGS=4 unless noted):
- Reset then write: reset, we=1 wsel=2 w=0xA5, next cycle rsel0=2 -> read0=0xA5 one cycle later; read1 (rsel1=0) = 0x00.
- Write-enable gating: we=0 wsel=1 w=0xFF -> reg1 stays 0x00; read0 on rsel0=1 = 0x00, drop_err=0.
- Bypass: same cycle we=1 wsel=3 w=0x3C, rsel0=rsel1=3:
  - BYPASS=1: read0=read1=0x3C next edge.
  - BYPASS=0 build: read0=read1=0x00, then 0x3C the following cycle.
- Clear sweep: load regs with 0x11/0x22/0x33/0x44, pulse clr:
  - busy high exactly 4 cycles.
  - rsel0=3 held throughout: reads 0x44 until the cycle after reg3 is cleared, then 0x00.
  - all regs 0 afterwards.
- Conflicts:
  - clr+we same cycle (wsel=0, w=0x55) -> reg0 = 0x00 after sweep, drop_err=1.
  - we during busy -> discarded, drop_err stays 1 until rst_n pulse.
- Mid-sweep reset and odd depth:
  - rst_n low in 2nd sweep cycle -> busy=0, reads 0 immediately after release.
  - NREGS=3: rsel0=3 -> read0=0; we to wsel=3 ignored, drop_err=0.
